// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - csr_num_e : 12-bit CSR numbers implemented (or decoded) by csr_file
//   - csr_op_e  : Zicsr operation encoding on csr_op_i
//   - mstatus / mie / mip bit positions and the mtvec mode encoding
//   - csr_wval  : read-modify-write value for a given op
package csr_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_MHARTID   = 12'hF14
  } csr_num_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  localparam int unsigned IRQ_SW_BIT    = 3;
  localparam int unsigned IRQ_TIMER_BIT = 7;
  localparam int unsigned IRQ_EXT_BIT   = 11;

  localparam logic [31:0] IRQ_MASK = (32'h1 << IRQ_SW_BIT)
                                   | (32'h1 << IRQ_TIMER_BIT)
                                   | (32'h1 << IRQ_EXT_BIT);

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  function automatic logic [31:0] csr_wval(input csr_op_e op,
                                           input logic [31:0] old,
                                           input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: csr_wval = wdata;
      CSR_OP_RS: csr_wval = old | wdata;
      CSR_OP_RC: csr_wval = old & ~wdata;
      default:   csr_wval = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit free-running counter with 32-bit half writes.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_wr_lo       : replace bits [31:0] with i_wdata
//   i_wr_hi       : replace bits [63:32] with i_wdata
//   i_wdata       : write data for either half
//   i_inc         : increment enable (ignored in a cycle with a write)
//   o_count       : current counter value
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  input  logic        i_inc,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // A software write to either half freezes the other half for that cycle,
  // so the written value is exactly what is read back next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= 64'd0;
    end else if (i_wr_lo) begin
      r_count[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_count[63:32] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the milano core.
// Executes Zicsr RW/RS/RC with a combinational old-value read port, applies
// trap entry and mret updates, tracks pending interrupts and drives the trap
// vector. Optional 64-bit mcycle/minstret counters under `CSR_COUNTERS_EN`.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   csr_addr_i/op_i/wdata_i  : CSR access (op 00 none, 01 RW, 10 RS, 11 RC)
//   csr_rdata_o, csr_illegal_o : old value (0 when illegal), illegal flag
//   instret_i                : instruction retired (counters only)
//   irq_ext_i/timer_i/sw_i   : level interrupt requests
//   trap_valid_i/cause_i/pc_i/tval_i : trap entry
//   mret_i                   : mret commit
//   trap_vector_o, mepc_o, irq_pending_o : to fetch / controller
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mip;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic        r_irq_pending;

  csr_num_e    w_addr;
  csr_op_e     w_op;
  logic [31:0] w_mstatus;
  logic [31:0] w_mip;
  logic [31:0] w_old;
  logic [31:0] w_wval;
  logic [31:0] w_tvec_base;
  logic        w_impl;
  logic        w_ro;
  logic        w_is_write;
  logic        w_illegal;
  logic        w_we;

  assign w_addr = csr_num_e'(csr_addr_i);
  assign w_op   = csr_op_e'(csr_op_i);

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_wr_lo (w_we && (w_addr == CSR_MCYCLE)),
    .i_wr_hi (w_we && (w_addr == CSR_MCYCLEH)),
    .i_wdata (w_wval),
    .i_inc   (1'b1),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_wr_lo (w_we && (w_addr == CSR_MINSTRET)),
    .i_wr_hi (w_we && (w_addr == CSR_MINSTRETH)),
    .i_wdata (w_wval),
    .i_inc   (instret_i),
    .o_count (w_minstret)
  );
`else
  logic w_unused_instret;
  assign w_unused_instret = instret_i;
`endif

  // mstatus view: MPP is hard-wired to M-mode, only MIE/MPIE are stored.
  always_comb begin
    w_mstatus                   = 32'h0000_1800;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
  end

  always_comb begin
    w_mip                = 32'h0;
    w_mip[IRQ_EXT_BIT]   = irq_ext_i;
    w_mip[IRQ_TIMER_BIT] = irq_timer_i;
    w_mip[IRQ_SW_BIT]    = irq_sw_i;
  end

  // Read mux; w_impl doubles as the address decoder for legality.
  always_comb begin
    w_old  = 32'h0;
    w_impl = 1'b1;
    case (w_addr)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MISA:      w_old = MISA_VALUE;
      CSR_MIE:       w_old = r_mie;
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MTVAL:     w_old = r_mtval;
      CSR_MIP:       w_old = r_mip;
      CSR_MHARTID:   w_old = MHARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    w_old = w_mcycle[31:0];
      CSR_MCYCLEH:   w_old = w_mcycle[63:32];
      CSR_MINSTRET:  w_old = w_minstret[31:0];
      CSR_MINSTRETH: w_old = w_minstret[63:32];
`endif
      default:       w_impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal on read-only
  // CSRs and must not count as a write (matters for counter suppression).
  assign w_ro       = (w_addr == CSR_MHARTID) || (w_addr == CSR_MISA);
  assign w_is_write = (w_op == CSR_OP_RW) || (csr_wdata_i != 32'h0);
  assign w_illegal  = (w_op != CSR_OP_NONE) && (!w_impl || (w_ro && w_is_write));
  assign w_we       = (w_op != CSR_OP_NONE) && !w_illegal && w_is_write;
  assign w_wval     = csr_wval(w_op, w_old, csr_wdata_i);

  assign csr_rdata_o   = w_illegal ? 32'h0 : w_old;
  assign csr_illegal_o = w_illegal;

  // Trap beats mret, and both beat a software write to mstatus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (trap_valid_i) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_we && (w_addr == CSR_MSTATUS)) begin
      r_mstatus_mie  <= w_wval[MSTATUS_MIE_BIT];
      r_mstatus_mpie <= w_wval[MSTATUS_MPIE_BIT];
    end
  end

  // Trap state: a trap in the same cycle overrides the software write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
      r_mtval  <= 32'h0;
    end else if (trap_valid_i) begin
      r_mepc   <= {trap_pc_i[31:2], 2'b00};
      r_mcause <= trap_cause_i;
      r_mtval  <= trap_tval_i;
    end else if (w_we) begin
      if (w_addr == CSR_MEPC)   r_mepc   <= {w_wval[31:2], 2'b00};
      if (w_addr == CSR_MCAUSE) r_mcause <= w_wval;
      if (w_addr == CSR_MTVAL)  r_mtval  <= w_wval;
    end
  end

  // Plain software registers; mtvec modes other than vectored fall to direct.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtvec    <= MTVEC_RESET;
      r_mie      <= 32'h0;
      r_mscratch <= 32'h0;
    end else if (w_we) begin
      if (w_addr == CSR_MTVEC) begin
        r_mtvec <= {w_wval[31:2], (w_wval[1:0] == MTVEC_MODE_VECTORED) ?
                                  MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT};
      end
      if (w_addr == CSR_MIE)      r_mie      <= w_wval & IRQ_MASK;
      if (w_addr == CSR_MSCRATCH) r_mscratch <= w_wval;
    end
  end

  // mip samples the request lines; pending is registered once more so it
  // lags mip by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mip         <= 32'h0;
      r_irq_pending <= 1'b0;
    end else begin
      r_mip         <= w_mip;
      r_irq_pending <= r_mstatus_mie && ((r_mie & r_mip) != 32'h0);
    end
  end

  assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
  assign trap_vector_o = ((r_mtvec[1:0] == MTVEC_MODE_VECTORED) && trap_cause_i[31]) ?
                         (w_tvec_base + {25'b0, trap_cause_i[4:0], 2'b00}) : w_tvec_base;
  assign mepc_o        = r_mepc;
  assign irq_pending_o = r_irq_pending;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file. Table-driven vectors,
// hand-written multi-cycle sequences, and randomized traffic compared every
// cycle against an architectural model of the CSR state.
module tb_csr_file;

  localparam logic [31:0] HART     = 32'h0000_00A5;
  localparam logic [31:0] MISA     = 32'h4000_0100;
  localparam logic [31:0] TVEC_RST = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] d_addr = '0;
  logic [1:0]  d_op = '0;
  logic [31:0] d_wdata = '0;
  logic        d_instret = 1'b0, d_ext = 1'b0, d_tim = 1'b0, d_sw = 1'b0;
  logic        d_trap = 1'b0, d_mret = 1'b0;
  logic [31:0] d_cause = '0, d_pc = '0, d_tval = '0;

  logic [31:0] o_rdata, o_vec, o_mepc;
  logic        o_ill, o_pend;

  int checks = 0;
  int errors = 0;

  csr_file #(.MHARTID(HART), .MISA_VALUE(MISA), .MTVEC_RESET(TVEC_RST)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .csr_addr_i(d_addr), .csr_op_i(d_op), .csr_wdata_i(d_wdata),
    .csr_rdata_o(o_rdata), .csr_illegal_o(o_ill),
    .instret_i(d_instret),
    .irq_ext_i(d_ext), .irq_timer_i(d_tim), .irq_sw_i(d_sw),
    .trap_valid_i(d_trap), .trap_cause_i(d_cause), .trap_pc_i(d_pc),
    .trap_tval_i(d_tval), .mret_i(d_mret),
    .trap_vector_o(o_vec), .mepc_o(o_mepc), .irq_pending_o(o_pend)
  );

  // Architectural model state
  typedef struct packed {
    logic        mie_b;
    logic        mpie_b;
    logic [31:0] mie, mip, mtvec, mscratch, mepc, mcause, mtval;
    logic        pend;
    logic [63:0] cyc, ins;
  } st_t;

  st_t m;

  function automatic st_t reset_st();
    st_t s;
    s = '0;
    s.mtvec = TVEC_RST;
    return s;
  endfunction

  function automatic bit impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
      12'h342, 12'h343, 12'h344, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd_val(input st_t s, input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | {24'b0, s.mpie_b, 3'b0, s.mie_b, 3'b0};
      12'h301: return MISA;
      12'h304: return s.mie;
      12'h305: return s.mtvec;
      12'h340: return s.mscratch;
      12'h341: return s.mepc;
      12'h342: return s.mcause;
      12'h343: return s.mtval;
      12'h344: return s.mip;
      12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
      12'hB00: return s.cyc[31:0];
      12'hB80: return s.cyc[63:32];
      12'hB02: return s.ins[31:0];
      12'hB82: return s.ins[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [11:0] a, input logic [1:0] op,
                                    input logic [31:0] wd);
    bit ro, wr;
    ro = (a == 12'hF14) || (a == 12'h301);
    wr = (op == 2'b01) || (wd != 32'h0);
    return (op != 2'b00) && (!impl(a) || (ro && wr));
  endfunction

  // Next architectural state from the rules: write, then mret, then trap
  // (later assignments win, giving trap > mret > write).
  function automatic st_t model_next(input st_t s);
    st_t n;
    logic [31:0] old, nv;
    bit wr;
    n = s;
    n.pend = s.mie_b & (|(s.mie & s.mip));
    n.mip  = {20'b0, d_ext, 3'b0, d_tim, 3'b0, d_sw, 3'b0};
    n.cyc  = s.cyc + 64'd1;
    n.ins  = s.ins + {63'b0, d_instret};
    old = rd_val(s, d_addr);
    nv  = (d_op == 2'b01) ? d_wdata : (d_op == 2'b10) ? (old | d_wdata) : (old & ~d_wdata);
    wr  = (d_op != 2'b00) && !is_illegal(d_addr, d_op, d_wdata) &&
          ((d_op == 2'b01) || (d_wdata != 32'h0));
    if (wr) begin
      case (d_addr)
        12'h300: begin n.mie_b = nv[3]; n.mpie_b = nv[7]; end
        12'h304: n.mie = nv & 32'h888;
        12'h305: n.mtvec = {nv[31:2], (nv[1:0] == 2'b01) ? 2'b01 : 2'b00};
        12'h340: n.mscratch = nv;
        12'h341: n.mepc = nv & ~32'h3;
        12'h342: n.mcause = nv;
        12'h343: n.mtval = nv;
        12'hB00: n.cyc = {s.cyc[63:32], nv};
        12'hB80: n.cyc = {nv, s.cyc[31:0]};
        12'hB02: n.ins = {s.ins[63:32], nv};
        12'hB82: n.ins = {nv, s.ins[31:0]};
        default: ;
      endcase
    end
    if (d_mret) begin
      n.mie_b  = s.mpie_b;
      n.mpie_b = 1'b1;
    end
    if (d_trap) begin
      n.mepc   = d_pc & ~32'h3;
      n.mcause = d_cause;
      n.mtval  = d_tval;
      n.mpie_b = s.mie_b;
      n.mie_b  = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) m <= reset_st();
    else         m <= model_next(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [31:0] er, ev;
    bit ei;
    ei = is_illegal(d_addr, d_op, d_wdata);
    er = ei ? 32'h0 : rd_val(m, d_addr);
    ev = {m.mtvec[31:2], 2'b00};
    if (m.mtvec[1:0] == 2'b01 && d_cause[31]) ev = ev + {25'b0, d_cause[4:0], 2'b00};
    chk("m_rdata", o_rdata, er);
    chkb("m_illegal", o_ill, ei);
    chk("m_vector", o_vec, ev);
    chk("m_mepc", o_mepc, m.mepc);
    chkb("m_pending", o_pend, m.pend);
  endtask

  task automatic sample();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    d_addr = a; d_op = op; d_wdata = wd;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ill;
  } vec_t;

  vec_t tbl[19];
  logic [11:0] addrs[16];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{12'h300, 2'b00, 32'h0,         32'h0000_1800, 1'b0};
    tbl[1]  = '{12'hF14, 2'b00, 32'h0,         HART,          1'b0};
    tbl[2]  = '{12'h305, 2'b00, 32'h0,         TVEC_RST,      1'b0};
    tbl[3]  = '{12'h301, 2'b10, 32'h0,         MISA,          1'b0};
    tbl[4]  = '{12'h301, 2'b11, 32'h1,         32'h0,         1'b1};
    tbl[5]  = '{12'h340, 2'b01, 32'h1234_5678, 32'h0,         1'b0};
    tbl[6]  = '{12'h340, 2'b10, 32'h0000_000F, 32'h1234_5678, 1'b0};
    tbl[7]  = '{12'h340, 2'b11, 32'h0000_00FF, 32'h1234_567F, 1'b0};
    tbl[8]  = '{12'h340, 2'b00, 32'h0,         32'h1234_5600, 1'b0};
    tbl[9]  = '{12'hF14, 2'b01, 32'h5,         32'h0,         1'b1};
    tbl[10] = '{12'hF14, 2'b00, 32'h0,         HART,          1'b0};
    tbl[11] = '{12'h7C0, 2'b01, 32'h1,         32'h0,         1'b1};
    tbl[12] = '{12'h305, 2'b01, 32'h0000_0103, TVEC_RST,      1'b0};
    tbl[13] = '{12'h305, 2'b00, 32'h0,         32'h0000_0100, 1'b0};
    tbl[14] = '{12'h341, 2'b01, 32'h0000_0207, 32'h0,         1'b0};
    tbl[15] = '{12'h341, 2'b00, 32'h0,         32'h0000_0204, 1'b0};
    tbl[16] = '{12'h344, 2'b01, 32'h0000_FFFF, 32'h0,         1'b0};
    tbl[17] = '{12'h344, 2'b00, 32'h0,         32'h0,         1'b0};
    tbl[18] = '{12'h343, 2'b10, 32'h0,         32'h0,         1'b0};
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h3A0};

    // Reset state, checked while reset is held
    set_op(12'h300, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    cmp_model();
    chk("rst_mstatus", o_rdata, 32'h0000_1800);
    @(negedge clk);
    rst_ni = 1'b1;
    adv();

    for (int i = 0; i < 19; i++) begin
      set_op(tbl[i].addr, tbl[i].op, tbl[i].wd);
      sample();
      chk($sformatf("tbl%0d_rdata", i), o_rdata, tbl[i].rd);
      chkb($sformatf("tbl%0d_illegal", i), o_ill, tbl[i].ill);
      adv();
    end

    // Interrupt path: mip one cycle after the request, pending one later
    set_op(12'h300, 2'b10, 32'h8); sample(); adv();
    set_op(12'h304, 2'b10, 32'h800); sample(); adv();
    set_op(12'h344, 2'b00, 32'h0); d_ext = 1'b1;
    sample(); chk("irq_mip_t0", o_rdata, 32'h0); chkb("irq_pend_t0", o_pend, 1'b0); adv();
    sample(); chk("irq_mip_t1", o_rdata, 32'h800); chkb("irq_pend_t1", o_pend, 1'b0); adv();
    sample(); chkb("irq_pend_t2", o_pend, 1'b1); adv();

    // Vectored trap colliding with a software mepc write
    set_op(12'h305, 2'b01, 32'h0000_0101); sample(); adv();
    set_op(12'h341, 2'b01, 32'hCAFE_0000);
    d_trap = 1'b1; d_cause = 32'h8000_0007; d_pc = 32'h0000_0206; d_tval = 32'hDEAD_BEEF;
    sample(); chk("trap_vector", o_vec, 32'h0000_011C); adv();
    d_trap = 1'b0; set_op(12'h300, 2'b00, 32'h0);
    sample(); chk("trap_mstatus", o_rdata, 32'h0000_1880); chk("trap_mepc", o_mepc, 32'h204); adv();
    set_op(12'h342, 2'b00, 32'h0); d_cause = 32'h0000_0002;
    sample(); chk("trap_mcause", o_rdata, 32'h8000_0007); chk("exc_vector", o_vec, 32'h100); adv();
    set_op(12'h300, 2'b00, 32'h0); d_mret = 1'b1; sample(); adv();
    d_mret = 1'b0;
    sample(); chk("mret_mstatus", o_rdata, 32'h0000_1888); adv();

`ifdef CSR_COUNTERS_EN
    set_op(12'hB80, 2'b01, 32'h0); sample(); adv();
    set_op(12'hB00, 2'b01, 32'hFFFF_FFFF); sample(); adv();
    set_op(12'hB00, 2'b00, 32'h0); sample(); chk("cyc_lo_held", o_rdata, 32'hFFFF_FFFF); adv();
    set_op(12'hB80, 2'b00, 32'h0); sample(); chk("cyc_hi_carry", o_rdata, 32'h1); adv();
    set_op(12'hB80, 2'b01, 32'hFFFF_FFFF); sample(); adv();
    set_op(12'hB00, 2'b01, 32'hFFFF_FFFF); sample(); adv();
    set_op(12'hB80, 2'b00, 32'h0); sample(); chk("cyc_hi_max", o_rdata, 32'hFFFF_FFFF); adv();
    sample(); chk("cyc_hi_wrap", o_rdata, 32'h0); adv();
    set_op(12'hB00, 2'b00, 32'h0); sample(); chk("cyc_lo_wrap", o_rdata, 32'h1); adv();
`else
    set_op(12'hB00, 2'b00, 32'h0); sample(); chk("cnt_off_read", o_rdata, 32'h0); adv();
    set_op(12'hB00, 2'b01, 32'h1); sample(); chkb("cnt_off_ill", o_ill, 1'b1); adv();
    set_op(12'hB82, 2'b10, 32'h0); sample(); chkb("cnt_off_ill_h", o_ill, 1'b1); adv();
`endif

    // Asynchronous reset in the middle of a cycle
    set_op(12'h340, 2'b01, 32'h0000_0055); sample(); adv();
    set_op(12'h340, 2'b00, 32'h0);
    #2;
    chk("pre_rst_mscratch", o_rdata, 32'h55);
    rst_ni = 1'b0;
    #1;
    chk("arst_mscratch", o_rdata, 32'h0);
    chk("arst_mepc", o_mepc, 32'h0);
    chkb("arst_pend", o_pend, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    adv();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_op(addrs[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      d_instret = 1'($urandom_range(0, 1));
      d_ext  = ($urandom_range(0, 3) == 0);
      d_tim  = ($urandom_range(0, 3) == 0);
      d_sw   = ($urandom_range(0, 3) == 0);
      d_trap = ($urandom_range(0, 9) == 0);
      d_mret = ($urandom_range(0, 9) == 0);
      d_cause = ($urandom_range(0, 1) == 1) ? {1'b1, 26'b0, 5'($urandom)} : $urandom;
      d_pc   = $urandom;
      d_tval = $urandom;
      sample();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
